// File: rtl/pit_counter.sv
// pit_counter: one 8253-style timer channel, modes 0-5 with read-back latches.
// Define PIT_BCD_EN to honour the BCD bit of the control word.
`timescale 1ns/1ps
module pit_counter (
  input  logic       clkinput,
  input  logic       rst_n,
  input  logic       ReadSignal,
  input  logic       WriteSignal,
  input  logic       gate,
  output logic       out,
  input  logic [5:0] ControlWord,
  input  logic       EnableCounterLatch,
  input  logic       EnableStatusLatch,
  inout  wire  [7:0] Data
);

  logic [5:0]  cw;
  logic [15:0] cr;
  logic [15:0] ce;
  logic [15:0] olatch;
  logic [7:0]  slatch;
  logic [7:0]  dout;
  logic        wr_msb;
  logic        rd_msb;
  logic        nullcnt;
  logic        run;
  logic        load_pend;
  logic        armed;
  logic        olatched;
  logic        slatched;
  logic        rd_q;
  logic        wr_q;
  logic        cl_q;
  logic        sl_q;
  logic        gate_q;

  logic        prog;
  logic        rd_rise;
  logic        wr_rise;
  logic        cl_rise;
  logic        sl_rise;
  logic        gate_rise;
  logic        bcd;
  logic [2:0]  mode;
  logic [2:0]  mode_n;
  logic [1:0]  rw;
  logic [1:0]  rw_n;
  logic        wptr;
  logic        wr_done;
  logic        trig;
  logic        term3;
  logic        rd_hi;
  logic [15:0] neff;
  logic [15:0] ldval;
  logic [15:0] dec_1;
  logic [15:0] dec_2;
  logic [15:0] src;
  logic [7:0]  rbyte;

  // M2M1=11 aliases modes 2/3
  function automatic logic [2:0] map_mode(input logic [2:0] m);
    return (m[2] & m[1]) ? {1'b0, m[1:0]} : m;
  endfunction

  function automatic logic [15:0] dec1(
    input logic [15:0] v,
    input logic        b
  );
    logic [15:0] r;
    logic        br;
    r  = v;
    br = 1'b1;
    if (!b) begin
      r = v - 16'd1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (br) begin
          if (v[4*i +: 4] == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd1;
            br = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

`ifdef PIT_BCD_EN
  assign bcd = cw[0];
`else
  assign bcd = 1'b0;
`endif

  assign prog      = ControlWord != cw;
  assign rd_rise   = ReadSignal & ~rd_q;
  assign wr_rise   = WriteSignal & ~wr_q;
  assign cl_rise   = EnableCounterLatch & ~cl_q;
  assign sl_rise   = EnableStatusLatch & ~sl_q;
  assign gate_rise = gate & ~gate_q;

  assign rw     = cw[5:4];
  assign mode   = map_mode(cw[3:1]);
  assign rw_n   = prog ? ControlWord[5:4] : rw;
  assign mode_n = prog ? map_mode(ControlWord[3:1]) : mode;
  assign wptr   = wr_msb & ~prog;

  assign wr_done = wr_rise & ((rw_n == 2'b01) | (rw_n == 2'b10) |
                              ((rw_n == 2'b11) & wptr));

  assign trig =
    (wr_done & (mode_n != 3'd1) & (mode_n != 3'd5)) |
    (gate_rise & ~prog & (mode != 3'd0) & (mode != 3'd4));

  assign neff  = ((mode == 3'd2 || mode == 3'd3) && cr == 16'd1)
               ? 16'd2 : cr;
  assign ldval = (mode == 3'd3) ? {neff[15:1], 1'b0} : neff;
  assign dec_1 = dec1(ce, bcd);
  assign dec_2 = dec1(dec_1, bcd);

  // odd counts stretch the high half by one clock
  assign term3 = (out & neff[0]) ? (ce == 16'd0) : (ce == 16'd2);

  assign src   = olatched ? olatch : ce;
  assign rd_hi = (rw == 2'b10) | ((rw == 2'b11) & rd_msb);
  assign rbyte = rd_hi ? src[15:8] : src[7:0];

  assign Data = (ReadSignal & ~WriteSignal) ? dout : 8'hzz;

  always_ff @(posedge clkinput) begin
    if (!rst_n) begin
      cw        <= '0;
      cr        <= '0;
      ce        <= '0;
      olatch    <= '0;
      slatch    <= '0;
      dout      <= '0;
      wr_msb    <= 1'b0;
      rd_msb    <= 1'b0;
      nullcnt   <= 1'b1;
      run       <= 1'b0;
      load_pend <= 1'b0;
      armed     <= 1'b0;
      olatched  <= 1'b0;
      slatched  <= 1'b0;
      out       <= 1'b1;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      cl_q      <= 1'b0;
      sl_q      <= 1'b0;
      gate_q    <= 1'b0;
    end else begin
      rd_q   <= ReadSignal;
      wr_q   <= WriteSignal;
      cl_q   <= EnableCounterLatch;
      sl_q   <= EnableStatusLatch;
      gate_q <= gate;

      if (load_pend) begin
        load_pend <= 1'b0;
        run       <= 1'b1;
        nullcnt   <= 1'b0;
        armed     <= 1'b1;
        ce        <= ldval;
        out       <= !(mode == 3'd0 || mode == 3'd1);
      end else if (run) begin
        unique case (mode)
          3'd0: begin
            if (gate) begin
              ce <= dec_1;
              if (ce == 16'd1) out <= 1'b1;
            end
          end
          3'd1: begin
            ce <= dec_1;
            if (ce == 16'd1) out <= 1'b1;
          end
          3'd2: begin
            if (!gate) begin
              out <= 1'b1;
            end else if (ce == 16'd1) begin
              ce  <= neff;
              out <= 1'b1;
            end else begin
              ce  <= dec_1;
              out <= (ce != 16'd2);
            end
          end
          3'd3: begin
            if (!gate) begin
              out <= 1'b1;
            end else if (term3) begin
              ce  <= ldval;
              out <= ~out;
            end else begin
              ce <= dec_2;
            end
          end
          default: begin
            out <= 1'b1;
            if (gate || mode == 3'd5) begin
              ce <= dec_1;
              if (ce == 16'd1 && armed) begin
                out   <= 1'b0;
                armed <= 1'b0;
              end
            end
          end
        endcase
      end

      if (prog) begin
        cw        <= ControlWord;
        wr_msb    <= 1'b0;
        rd_msb    <= 1'b0;
        nullcnt   <= 1'b1;
        run       <= 1'b0;
        load_pend <= 1'b0;
        armed     <= 1'b0;
        out       <= (map_mode(ControlWord[3:1]) != 3'd0);
      end

      if (wr_rise) begin
        case (rw_n)
          2'b01: cr <= {8'h00, Data};
          2'b10: cr <= {Data, 8'h00};
          2'b11: begin
            if (wptr) cr[15:8] <= Data;
            else      cr[7:0]  <= Data;
          end
          default: ;
        endcase
        if (rw_n == 2'b11) wr_msb <= ~wptr;
        if (mode_n == 3'd0) begin
          out <= 1'b0;
          run <= 1'b0;
        end
        if (wr_done) nullcnt <= 1'b1;
      end

      if (trig) load_pend <= 1'b1;

      if (cl_rise && !olatched) begin
        olatch   <= ce;
        olatched <= 1'b1;
      end
      if (sl_rise && !slatched) begin
        slatch   <= {out, nullcnt, cw};
        slatched <= 1'b1;
      end

      if (rd_rise) begin
        if (slatched) begin
          dout     <= slatch;
          slatched <= 1'b0;
        end else begin
          dout <= rbyte;
          if (rw == 2'b11) rd_msb <= ~rd_msb;
          if (olatched && !(rw == 2'b11 && !rd_msb)) olatched <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pit_counter.sv
// tb_pit_counter: directed checks of the 8253 channel
// (reset, modes 0/2/3/5, latches, bus direction).
`timescale 1ns/1ps
module tb_pit_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd;
  logic       wr;
  logic       gate;
  logic       ecl;
  logic       esl;
  logic [5:0] cwd;
  logic       out;
  wire  [7:0] data;
  logic [7:0] drv;
  logic       drv_en;
  logic [7:0] v;
  logic [15:0] lows;
  logic [15:0] expm;
  int         n_chk = 0;
  int         n_pass = 0;
  int         cnt;

  always #5 clk = ~clk;

  assign data = drv_en ? drv : 8'hzz;

  pit_counter dut (
    .clkinput          (clk),
    .rst_n             (rst_n),
    .ReadSignal        (rd),
    .WriteSignal       (wr),
    .gate              (gate),
    .out               (out),
    .ControlWord       (cwd),
    .EnableCounterLatch(ecl),
    .EnableStatusLatch (esl),
    .Data              (data)
  );

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    drv    = b;
    drv_en = 1'b1;
    wr     = 1'b1;
    cyc(1);
    wr     = 1'b0;
    drv_en = 1'b0;
    cyc(1);
  endtask

  task automatic rd_byte(output logic [7:0] b);
    rd = 1'b1;
    cyc(1);
    b  = data;
    rd = 1'b0;
    cyc(1);
  endtask

  task automatic latch_status();
    esl = 1'b1;
    cyc(1);
    esl = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    gate   = 1'b0;
    ecl    = 1'b0;
    esl    = 1'b0;
    cwd    = 6'b0;
    drv    = 8'h00;
    drv_en = 1'b0;
    cyc(2);
    check("rst_out", {15'b0, out}, 16'd1);
    check("rst_dz", {15'b0, data === 8'hzz}, 16'd1);
    rst_n = 1'b1;
    cyc(1);
    check("rst_out2", {15'b0, out}, 16'd1);
    rd_byte(v);
    check("rst_ce", {8'h0, v}, 16'h0000);

    // mode 5, RW=01
    cwd = 6'b011010;
    cyc(1);
    latch_status();
    rd_byte(v);
    check("m5_status", {8'h0, v}, 16'h00DA);
    wr_byte(8'd30);
    gate = 1'b1;
    cyc(1);
    gate = 1'b0;
    cyc(1);
    rd_byte(v);
    check("m5_ce30", {8'h0, v}, 16'd30);
    cyc(27);
    check("m5_t30", {15'b0, out}, 16'd1);
    cyc(1);
    check("m5_t31", {15'b0, out}, 16'd0);
    cyc(1);
    check("m5_t32", {15'b0, out}, 16'd1);

    wr_byte(8'd5);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (!out) cnt++;
    end
    check("m5_nopulse", cnt[15:0], 16'd0);

    gate = 1'b1;
    cyc(1);
    gate = 1'b0;
    lows = '0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      lows[i] = ~out;
    end
    check("m5_pulse", lows, 16'h0040);

    gate = 1'b1;
    cyc(1);
    lows = '0;
    for (int i = 1; i <= 12; i++) begin
      gate = (i == 3);
      cyc(1);
      lows[i] = ~out;
    end
    gate = 1'b0;
    check("m5_retrig", lows, 16'h0200);

    // mode 0, RW=11
    cwd = 6'b110000;
    cyc(1);
    check("m0_prog_out", {15'b0, out}, 16'd0);
    latch_status();
    rd_byte(v);
    check("m0_status0", {8'h0, v}, 16'h0070);
    gate = 1'b1;
    wr_byte(8'h34);
    wr_byte(8'h12);
    latch_status();
    rd_byte(v);
    check("m0_status1", {8'h0, v}, 16'h0030);
    cyc(97);
    gate = 1'b0;
    ecl  = 1'b1;
    cyc(1);
    ecl  = 1'b0;
    rd_byte(v);
    check("m0_lat_lsb", {8'h0, v}, 16'h00D0);
    rd_byte(v);
    check("m0_lat_msb", {8'h0, v}, 16'h0011);
    cyc(10);
    rd_byte(v);
    check("m0_frz_lsb", {8'h0, v}, 16'h00D0);
    rd_byte(v);
    check("m0_frz_msb", {8'h0, v}, 16'h0011);
    check("m0_out_low", {15'b0, out}, 16'd0);
    gate = 1'b1;
    cyc(4559);
    check("m0_pre_tc", {15'b0, out}, 16'd0);
    cyc(1);
    check("m0_tc", {15'b0, out}, 16'd1);
    cyc(5);
    check("m0_hold", {15'b0, out}, 16'd1);

    // mode 3, RW=01, count 5
    cwd = 6'b010110;
    cyc(1);
    wr_byte(8'd5);
    lows = '0;
    expm = '0;
    for (int i = 1; i <= 15; i++) begin
      cyc(1);
      lows[i] = out;
      expm[i] = ((i % 5) < 3);
    end
    check("m3_wave", lows, expm);
    cyc(3);
    check("m3_low", {15'b0, out}, 16'd0);
    gate = 1'b0;
    cyc(1);
    check("m3_gate0", {15'b0, out}, 16'd1);
    cyc(3);
    check("m3_gate0b", {15'b0, out}, 16'd1);

    // mode 2, RW=11, count 100
    gate = 1'b1;
    cwd  = 6'b110100;
    cyc(1);
    wr_byte(8'h64);
    wr_byte(8'h00);
    cyc(20);
    ecl = 1'b1;
    cyc(1);
    ecl = 1'b0;
    rd_byte(v);
    check("m2_lat_lsb", {8'h0, v}, 16'h0050);
    rd_byte(v);
    check("m2_lat_msb", {8'h0, v}, 16'h0000);
    rd_byte(v);
    check("m2_live_lsb", {8'h0, v}, 16'h004B);
    rd_byte(v);
    check("m2_live_msb", {8'h0, v}, 16'h0000);
    cyc(69);
    check("m2_t98", {15'b0, out}, 16'd1);
    cyc(1);
    check("m2_t99", {15'b0, out}, 16'd0);
    cyc(1);
    check("m2_t100", {15'b0, out}, 16'd1);
    cyc(98);
    check("m2_t198", {15'b0, out}, 16'd1);
    cyc(1);
    check("m2_t199", {15'b0, out}, 16'd0);

    rd = 1'b1;
    wr = 1'b1;
    #1;
    check("bus_wr_prio", {15'b0, data === 8'hzz}, 16'd1);
    rd = 1'b0;
    wr = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
